// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-master memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_IFETCH = 2'd1,
        OWN_DATA   = 2'd2
    } owner_e;

    localparam int unsigned DEF_ADDR_W       = 32;
    localparam int unsigned DEF_MAX_D_STREAK = 4;
    localparam int unsigned STREAK_W         = 4;

endpackage

// File: rtl/mem_arb_streak.sv
// Saturating count of consecutive data grants taken while fetch is waiting.
module mem_arb_streak
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX = DEF_MAX_D_STREAK
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_i,
    input  logic                inc_i,
    output logic [STREAK_W-1:0] streak_o
);

    localparam logic [STREAK_W-1:0] MAX_S = STREAK_W'(MAX);

    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_d;

    always_comb begin
        streak_d = streak_q;
        if (clr_i) begin
            streak_d = '0;
        end else if (inc_i && (streak_q != MAX_S)) begin
            streak_d = streak_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    assign streak_o = streak_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and the LSU: data has
// priority, a streak limit bounds fetch starvation, and a lock holds the grant.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = DEF_MAX_D_STREAK,
    parameter int unsigned ADDR_W       = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [31:0]       i_rdata,
    input  logic              d_valid,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_wstrb,
    output logic              d_ready,
    output logic [31:0]       d_rdata,
    output logic              m_valid,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    input  logic              s_ready,
    input  logic [31:0]       s_rdata,
    output logic [1:0]        o_owner,
    output logic              o_abort
);

    localparam logic [STREAK_W-1:0] MAX_S = STREAK_W'(MAX_D_STREAK);

    owner_e              owner_q;
    owner_e              sel;
    logic                abort_q;
    logic [STREAK_W-1:0] streak;
    logic                i_hs;
    logic                d_hs;

    always_comb begin
        sel = OWN_NONE;
        if (owner_q != OWN_NONE) begin
            sel = owner_q;
        end else if (d_valid && i_valid) begin
            sel = (streak == MAX_S) ? OWN_IFETCH : OWN_DATA;
        end else if (d_valid) begin
            sel = OWN_DATA;
        end else if (i_valid) begin
            sel = OWN_IFETCH;
        end
    end

    // A withdrawn lock keeps sel on the old owner, so m_valid falls to 0 for that cycle.
    always_comb begin
        m_valid = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        case (sel)
            OWN_IFETCH: begin
                m_valid = i_valid && !rst;
                m_addr  = i_addr;
            end
            OWN_DATA: begin
                m_valid = d_valid && !rst;
                m_addr  = d_addr;
                m_wdata = d_wdata;
                m_wstrb = d_wstrb;
            end
            default: ;
        endcase
    end

    assign i_ready = s_ready && !rst && (sel == OWN_IFETCH);
    assign d_ready = s_ready && !rst && (sel == OWN_DATA);
    assign i_rdata = s_rdata;
    assign d_rdata = s_rdata;

    assign i_hs = i_valid && i_ready;
    assign d_hs = d_valid && d_ready;

    mem_arb_streak #(
        .MAX (MAX_D_STREAK)
    ) u_streak (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (i_hs || !i_valid),
        .inc_i    (d_hs && i_valid && !i_hs),
        .streak_o (streak)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= OWN_NONE;
            abort_q <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            if ((owner_q != OWN_NONE) && !m_valid) begin
                owner_q <= OWN_NONE;
                abort_q <= 1'b1;
            end else if (m_valid && !s_ready) begin
                owner_q <= sel;
            end else if (m_valid && s_ready) begin
                owner_q <= OWN_NONE;
            end
        end
    end

    assign o_owner = owner_q;
    assign o_abort = abort_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: stimulus queues expected
// handshakes, a negedge monitor pops and compares each accepted request.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        d_valid;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic [1:0]  o_owner;
    logic        o_abort;

    typedef struct {
        bit          is_d;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    bit   pat [10];
    int   ic;
    int   dc;

    mem_arbiter #(
        .MAX_D_STREAK (4),
        .ADDR_W       (32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_addr  (i_addr),
        .i_ready (i_ready),
        .i_rdata (i_rdata),
        .d_valid (d_valid),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_wstrb (d_wstrb),
        .d_ready (d_ready),
        .d_rdata (d_rdata),
        .m_valid (m_valid),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wstrb (m_wstrb),
        .s_ready (s_ready),
        .s_rdata (s_rdata),
        .o_owner (o_owner),
        .o_abort (o_abort)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input bit is_d, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic [31:0] rdata);
        exp_t x;
        x.is_d  = is_d;
        x.addr  = addr;
        x.wdata = wdata;
        x.wstrb = wstrb;
        x.rdata = rdata;
        q.push_back(x);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    // Monitor: every accepted request must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && ((i_valid && i_ready) || (d_valid && d_ready))) begin
            chk("hs_exclusive", {31'b0, (i_valid && i_ready) && (d_valid && d_ready)}, 32'd0);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_hs: got i_hs=%0b d_hs=%0b addr=%h expected none",
                         i_valid && i_ready, d_valid && d_ready, m_addr);
            end else begin
                e = q.pop_front();
                chk("hs_is_data", {31'b0, d_valid && d_ready}, {31'b0, e.is_d});
                chk("hs_m_addr", m_addr, e.addr);
                chk("hs_m_wdata", m_wdata, e.wdata);
                chk("hs_m_wstrb", {28'b0, m_wstrb}, {28'b0, e.wstrb});
                chk("hs_rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
            end
        end
    end

    initial begin
        pat = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        rst = 1'b1;
        i_valid = 1'b0; i_addr = '0;
        d_valid = 1'b1; d_addr = 32'h0000_0ff0; d_wdata = '0; d_wstrb = '0;
        s_ready = 1'b1; s_rdata = '0;

        // Reset state: ready and valid forced low even with a request present
        #3;
        chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
        chk("rst_d_ready", {31'b0, d_ready}, 32'd0);
        chk("rst_owner", {30'b0, o_owner}, 32'd0);
        chk("rst_abort", {31'b0, o_abort}, 32'd0);
        step;
        step;
        d_valid = 1'b0; s_ready = 1'b0; rst = 1'b0;

        // 1: fetch only
        for (int k = 0; k < 3; k++) begin
            i_valid = 1'b1; i_addr = 32'(4 * k);
            s_ready = 1'b1; s_rdata = 32'h1000_0000 + 32'(k);
            push(1'b0, 32'(4 * k), 32'h0, 4'h0, 32'h1000_0000 + 32'(k));
            settle;
            chk("t1_i_ready", {31'b0, i_ready}, 32'd1);
            chk("t1_m_addr", m_addr, 32'(4 * k));
            step;
        end

        // 2: priority and fairness, pattern D,D,D,D,I repeated
        ic = 0; dc = 0;
        for (int n = 0; n < 10; n++) begin
            i_valid = 1'b1; d_valid = 1'b1; s_ready = 1'b1;
            i_addr = 32'h40 + 32'(4 * ic);
            d_addr = 32'h200 + 32'(4 * dc);
            s_rdata = 32'h2000_0000 + 32'(n);
            if (pat[n]) begin
                push(1'b1, 32'h200 + 32'(4 * dc), 32'h0, 4'h0, 32'h2000_0000 + 32'(n));
                dc++;
            end else begin
                push(1'b0, 32'h40 + 32'(4 * ic), 32'h0, 4'h0, 32'h2000_0000 + 32'(n));
                ic++;
            end
            settle;
            step;
        end

        // 3: data lock holds against a rising fetch
        i_valid = 1'b0; d_valid = 1'b1; d_addr = 32'h100; s_ready = 1'b0;
        settle;
        chk("t3_m_valid", {31'b0, m_valid}, 32'd1);
        chk("t3_m_addr0", m_addr, 32'h100);
        step;
        i_valid = 1'b1; i_addr = 32'h80;
        for (int c = 1; c < 3; c++) begin
            settle;
            chk("t3_owner", {30'b0, o_owner}, 32'd2);
            chk("t3_m_addr", m_addr, 32'h100);
            chk("t3_i_ready", {31'b0, i_ready}, 32'd0);
            step;
        end
        s_ready = 1'b1; s_rdata = 32'h3333_3333;
        push(1'b1, 32'h100, 32'h0, 4'h0, 32'h3333_3333);
        settle;
        chk("t3_d_ready", {31'b0, d_ready}, 32'd1);
        step;
        d_valid = 1'b0; s_rdata = 32'h3333_4444;
        push(1'b0, 32'h80, 32'h0, 4'h0, 32'h3333_4444);
        settle;
        chk("t3_owner_clr", {30'b0, o_owner}, 32'd0);
        chk("t3_i_ready_next", {31'b0, i_ready}, 32'd1);
        step;

        // 4: abort of a locked fetch
        i_valid = 1'b1; i_addr = 32'hC0; s_ready = 1'b0;
        step;
        d_valid = 1'b1; d_addr = 32'h300;
        settle;
        chk("t4_owner_if", {30'b0, o_owner}, 32'd1);
        chk("t4_m_addr", m_addr, 32'hC0);
        chk("t4_d_wait", {31'b0, d_ready}, 32'd0);
        step;
        i_valid = 1'b0; s_ready = 1'b1; s_rdata = 32'h4444_4444;
        settle;
        chk("t4_m_valid_wd", {31'b0, m_valid}, 32'd0);
        chk("t4_d_blocked", {31'b0, d_ready}, 32'd0);
        chk("t4_abort_pre", {31'b0, o_abort}, 32'd0);
        step;
        push(1'b1, 32'h300, 32'h0, 4'h0, 32'h4444_4444);
        settle;
        chk("t4_abort", {31'b0, o_abort}, 32'd1);
        chk("t4_owner_none", {30'b0, o_owner}, 32'd0);
        chk("t4_d_ready", {31'b0, d_ready}, 32'd1);
        step;
        d_valid = 1'b0;
        settle;
        chk("t4_abort_end", {31'b0, o_abort}, 32'd0);
        step;

        // 5: write forwarding, then fetch zeroes write fields
        d_valid = 1'b1; d_addr = 32'h400; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
        s_ready = 1'b1; s_rdata = 32'h5555_5555;
        push(1'b1, 32'h400, 32'hDEAD_BEEF, 4'b0011, 32'h5555_5555);
        settle;
        chk("t5_m_wstrb", {28'b0, m_wstrb}, 32'h3);
        step;
        d_valid = 1'b0; i_valid = 1'b1; i_addr = 32'h500; s_rdata = 32'h5555_6666;
        push(1'b0, 32'h500, 32'h0, 4'h0, 32'h5555_6666);
        settle;
        chk("t5_if_wstrb", {28'b0, m_wstrb}, 32'h0);
        step;

        // 6: reset while data holds the lock
        i_valid = 1'b0; d_wdata = '0; d_wstrb = '0;
        d_valid = 1'b1; d_addr = 32'h600; s_ready = 1'b0;
        step;
        settle;
        chk("t6_owner_lock", {30'b0, o_owner}, 32'd2);
        rst = 1'b1; s_ready = 1'b1; s_rdata = 32'h6666_6666;
        #1;
        chk("t6_m_valid", {31'b0, m_valid}, 32'd0);
        chk("t6_d_ready", {31'b0, d_ready}, 32'd0);
        chk("t6_owner", {30'b0, o_owner}, 32'd0);
        step;
        rst = 1'b0;
        push(1'b1, 32'h600, 32'h0, 4'h0, 32'h6666_6666);
        settle;
        chk("t6_d_ready_rel", {31'b0, d_ready}, 32'd1);
        chk("t6_owner_rel", {30'b0, o_owner}, 32'd0);
        step;
        d_valid = 1'b0; s_ready = 1'b0;

        for (int w = 0; w < 20 && q.size() != 0; w++) begin
            step;
        end
        chk("queue_drained", 32'(q.size()), 32'd0);
        step;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
